wb_arbiter: RTL and testbench

Write-side front end of the integer register file. Collects writeback results from several functional units (ALU, load unit, mul/div) over valid/ready handshakes. Buffers one result per source, picks one per cycle with round-robin arbitration, and drives the register file's single write port (addr_rd / rd_data / wen) from a registered output stage.

---
 rtl/wb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/wb_arbiter.sv | 99 +++++++++
 tb/tb_wb_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback path.
package wb_pkg;

  localparam int REG_IDX_W  = 5;
  localparam int WB_XLEN    = 32;
  localparam int WB_NUM_SRC = 3;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [WB_XLEN-1:0]   data;
  } wb_req_t;

  typedef logic [WB_NUM_SRC-1:0] src_mask_t;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr.
module rr_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int PW      = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [PW-1:0]      idx
);

  int j;

  // Walk from farthest to nearest so the slot closest to ptr wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    j     = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (req[j]) begin
        grant = NUM_SRC'(1) << j;
        idx   = PW'(j);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback collector feeding the register file write port.
// Optional WB_FWD_EN exposes bypass outputs for the decode stage.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_SRC = WB_NUM_SRC,
  parameter int XLEN    = WB_XLEN
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [NUM_SRC-1:0]                   src_valid,
  output logic [NUM_SRC-1:0]                   src_ready,
  input  logic [NUM_SRC-1:0][REG_IDX_W-1:0]    src_rd,
  input  logic [NUM_SRC-1:0][XLEN-1:0]         src_data,
  output logic [REG_IDX_W-1:0]                 addr_rd,
  output logic [XLEN-1:0]                      rd_data,
  output logic                                 wen
`ifdef WB_FWD_EN
  ,
  output logic                                 fwd_valid,
  output logic [REG_IDX_W-1:0]                 fwd_addr,
  output logic [XLEN-1:0]                      fwd_data,
  output logic [NUM_SRC-1:0]                   fwd_hit_mask
`endif
);

  localparam int PW = $clog2(NUM_SRC);

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } req_t;

  req_t               ent_q [NUM_SRC];
  logic [NUM_SRC-1:0] ent_vld;
  logic [PW-1:0]      ptr;
  logic [NUM_SRC-1:0] grant;
  logic [PW-1:0]      gnt_idx;
  logic               gnt_any;
  req_t               sel;

  rr_arbiter #(
    .NUM_SRC(NUM_SRC),
    .PW     (PW)
  ) u_rr (
    .req  (ent_vld),
    .ptr  (ptr),
    .grant(grant),
    .idx  (gnt_idx)
  );

  assign gnt_any = |grant;
  assign sel     = ent_q[gnt_idx];

  // Ready never looks at src_valid, so no valid->ready loop.
  assign src_ready = (!reset || flush) ? '0 : (~ent_vld | grant);

  always_ff @(posedge clock) begin
    if (!reset) begin
      ent_vld <= '0;
      ptr     <= '0;
      wen     <= 1'b0;
      addr_rd <= '0;
      rd_data <= '0;
      for (int i = 0; i < NUM_SRC; i++) ent_q[i] <= '0;
    end else if (flush) begin
      ent_vld <= '0;
      wen     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i] && src_ready[i]) begin
          ent_vld[i] <= 1'b1;
          ent_q[i]   <= '{rd: src_rd[i], data: src_data[i]};
        end else if (grant[i]) begin
          ent_vld[i] <= 1'b0;
        end
      end
      if (gnt_any) begin
        ptr     <= PW'(next_idx(int'(gnt_idx), NUM_SRC));
        addr_rd <= sel.rd;
        rd_data <= sel.data;
        wen     <= (sel.rd != '0);
      end else begin
        wen <= 1'b0;
      end
    end
  end

`ifdef WB_FWD_EN
  assign fwd_valid = wen;
  assign fwd_addr  = addr_rd;
  assign fwd_data  = rd_data;
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_hit
    assign fwd_hit_mask[g] = ent_vld[g] && (ent_q[g].rd != '0);
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table plus corner sequences.
module tb_wb_arbiter;

  logic              clock;
  logic              reset;
  logic              flush;
  logic [2:0]        src_valid;
  logic [2:0]        src_ready;
  logic [2:0][4:0]   src_rd;
  logic [2:0][31:0]  src_data;
  logic [4:0]        addr_rd;
  logic [31:0]       rd_data;
  logic              wen;
`ifdef WB_FWD_EN
  logic              fwd_valid;
  logic [4:0]        fwd_addr;
  logic [31:0]       fwd_data;
  logic [2:0]        fwd_hit_mask;
`endif

  int compared   = 0;
  int mismatched = 0;

  wb_arbiter #(.NUM_SRC(3), .XLEN(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .src_rd   (src_rd),
    .src_data (src_data),
    .addr_rd  (addr_rd),
    .rd_data  (rd_data),
    .wen      (wen)
`ifdef WB_FWD_EN
    ,
    .fwd_valid   (fwd_valid),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data),
    .fwd_hit_mask(fwd_hit_mask)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Handshake rule: a stalled source keeps valid and payload steady.
  logic [2:0]       pst_stall = '0;
  logic [2:0][4:0]  pst_rd;
  logic [2:0][31:0] pst_data;

  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (pst_stall[i]) begin
        compared++;
        if (!src_valid[i] || src_rd[i] !== pst_rd[i] ||
            src_data[i] !== pst_data[i]) begin
          mismatched++;
          $display("FAIL hold src%0d: got v=%b rd=%0d d=%h want v=1 rd=%0d d=%h",
                   i, src_valid[i], src_rd[i], src_data[i],
                   pst_rd[i], pst_data[i]);
        end
      end
    end
    pst_stall = (reset && !flush) ? (src_valid & ~src_ready) : 3'b000;
    pst_rd    = src_rd;
    pst_data  = src_data;
  end

  typedef struct {
    logic             rs;
    logic             fl;
    logic [2:0]       v;
    logic [2:0][4:0]  r;
    logic [2:0][31:0] d;
    logic [2:0]       rdy;
    logic             w;
    logic [4:0]       a;
    logic [31:0]      dt;
  } vec_t;

  vec_t vec [19];
  int   nv = 0;

  task automatic addv(input logic rs, input logic [2:0] v,
                      input logic [2:0][4:0] r,
                      input logic [2:0][31:0] d, input logic [2:0] rdy,
                      input logic w, input logic [4:0] a,
                      input logic [31:0] dt);
    vec[nv] = '{rs: rs, fl: 1'b0, v: v, r: r, d: d, rdy: rdy,
                w: w, a: a, dt: dt};
    nv++;
  endtask

  task automatic drive(input logic [2:0] v, input logic [2:0][4:0] r,
                       input logic [2:0][31:0] d);
    src_valid = v;
    src_rd    = r;
    src_data  = d;
    #1;
  endtask

  task automatic chk_out(input string nm, input logic w,
                         input logic [4:0] a, input logic [31:0] dt);
    chk({nm, " wen"}, 32'(wen), 32'(w));
    chk({nm, " addr"}, 32'(addr_rd), 32'(a));
    chk({nm, " data"}, rd_data, dt);
  endtask

  logic [2:0][4:0]  ra, rb;
  logic [2:0][31:0] da, db;

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    src_valid = '0;
    src_rd    = '0;
    src_data  = '0;

    ra = {5'd0, 5'd0, 5'd5};
    da = {32'h0, 32'h0, 32'hDEADBEEF};
    rb = {5'd3, 5'd2, 5'd1};
    db = {32'h33, 32'h22, 32'h11};

    // single write, then reset, then round-robin with continuous valids
    addv(1, 3'b001, ra, da, 3'b111, 0, 5'd0, 32'h0);
    addv(1, 3'b000, ra, da, 3'b111, 0, 5'd0, 32'h0);
    addv(1, 3'b000, ra, da, 3'b111, 1, 5'd5, 32'hDEADBEEF);
    addv(1, 3'b000, ra, da, 3'b111, 0, 5'd5, 32'hDEADBEEF);
    addv(0, 3'b000, ra, da, 3'b000, 0, 5'd5, 32'hDEADBEEF);
    addv(1, 3'b111, rb, db, 3'b111, 0, 5'd0, 32'h0);
    addv(1, 3'b111, rb, db, 3'b001, 0, 5'd0, 32'h0);
    addv(1, 3'b111, rb, db, 3'b010, 1, 5'd1, 32'h11);
    addv(1, 3'b111, rb, db, 3'b100, 1, 5'd2, 32'h22);
    addv(1, 3'b111, rb, db, 3'b001, 1, 5'd3, 32'h33);
    addv(1, 3'b111, rb, db, 3'b010, 1, 5'd1, 32'h11);
    addv(1, 3'b111, rb, db, 3'b100, 1, 5'd2, 32'h22);
    addv(1, 3'b011, rb, db, 3'b001, 1, 5'd3, 32'h33);
    addv(1, 3'b010, rb, db, 3'b010, 1, 5'd1, 32'h11);
    addv(1, 3'b000, rb, db, 3'b100, 1, 5'd2, 32'h22);
    addv(1, 3'b000, rb, db, 3'b101, 1, 5'd3, 32'h33);
    addv(1, 3'b000, rb, db, 3'b111, 1, 5'd1, 32'h11);
    addv(1, 3'b000, rb, db, 3'b111, 1, 5'd2, 32'h22);
    addv(1, 3'b000, rb, db, 3'b111, 0, 5'd2, 32'h22);

    tick();
    tick();
    chk_out("reset", 0, 5'd0, 32'h0);
    chk("reset rdy", 32'(src_ready), 32'h0);

    for (int i = 0; i < nv; i++) begin
      reset     = vec[i].rs;
      flush     = vec[i].fl;
      src_valid = vec[i].v;
      src_rd    = vec[i].r;
      src_data  = vec[i].d;
      #1;
      chk($sformatf("v%0d rdy", i), 32'(src_ready), 32'(vec[i].rdy));
      chk_out($sformatf("v%0d", i), vec[i].w, vec[i].a, vec[i].dt);
      tick();
    end

    // x0: accepted and granted but never written
    drive(3'b010, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h1234, 32'h0});
    chk("x0 rdy0", 32'(src_ready[1]), 32'h1);
    tick();
    drive(3'b010, {5'd0, 5'd7, 5'd0}, {32'h0, 32'h55, 32'h0});
    chk("x0 rdy1", 32'(src_ready[1]), 32'h1);
    tick();
    drive(3'b000, '0, '0);
    chk_out("x0 first", 0, 5'd0, 32'h1234);
    tick();
    chk_out("x0 second", 1, 5'd7, 32'h55);

    // flush discards buffered results before they reach the output
    drive(3'b011, {5'd0, 5'd9, 5'd8}, {32'h0, 32'h99, 32'h88});
    chk("fl load rdy", 32'(src_ready), 32'h7);
    tick();
    flush = 1'b1;
    drive(3'b000, '0, '0);
    chk("fl rdy", 32'(src_ready), 32'h0);
    chk("fl wen0", 32'(wen), 32'h0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl wen1", 32'(wen), 32'h0);
    chk("fl empty", 32'(src_ready), 32'h7);
    tick();
    chk("fl wen2", 32'(wen), 32'h0);
    drive(3'b100, {5'd21, 5'd0, 5'd0}, {32'h2121, 32'h0, 32'h0});
    tick();
    drive(3'b000, '0, '0);
    tick();
    chk_out("fl fresh", 1, 5'd21, 32'h2121);

    // backpressure: src2 full and not granted sees ready low
    drive(3'b101, {5'd12, 5'd0, 5'd10}, {32'hC0, 32'h0, 32'hA0});
    tick();
    drive(3'b101, {5'd13, 5'd0, 5'd11}, {32'hC1, 32'h0, 32'hA1});
    chk("bp rdy", 32'(src_ready), 32'h3);
    tick();
    drive(3'b100, {5'd13, 5'd0, 5'd0}, {32'hC1, 32'h0, 32'h0});
    chk("bp rdy2", 32'(src_ready), 32'h6);
    chk_out("bp w0", 1, 5'd10, 32'hA0);
    tick();
    drive(3'b000, '0, '0);
    chk_out("bp w1", 1, 5'd12, 32'hC0);
    tick();
    chk_out("bp w2", 1, 5'd11, 32'hA1);
    tick();
    chk_out("bp w3", 1, 5'd13, 32'hC1);
    tick();
    chk("bp idle", 32'(wen), 32'h0);

    // reset while busy, then source 0 wins the first contention
    drive(3'b111, {5'd3, 5'd2, 5'd1}, {32'h53, 32'h52, 32'h51});
    tick();
    drive(3'b000, '0, '0);
    tick();
    reset = 1'b0;
    #1;
    chk("rm rdy", 32'(src_ready), 32'h0);
    chk("rm busy", 32'(wen), 32'h1);
    tick();
    reset = 1'b1;
    #1;
    chk_out("rm clr", 0, 5'd0, 32'h0);
    chk("rm empty", 32'(src_ready), 32'h7);
    drive(3'b111, {5'd6, 5'd5, 5'd4}, {32'h66, 32'h65, 32'h64});
    tick();
    drive(3'b000, '0, '0);
    tick();
    chk_out("rm w0", 1, 5'd4, 32'h64);
    tick();
    chk_out("rm w1", 1, 5'd5, 32'h65);
    tick();
    chk_out("rm w2", 1, 5'd6, 32'h66);
    tick();
    chk("rm idle", 32'(wen), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
